// File: rtl/mem_pkg.sv
// Shared types for the data memory responder: access sizes, FSM states, wait-state limit.
package mem_pkg;

  localparam int WAIT_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Encoding 2'b11 is folded onto WORD.
  function automatic size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      HALF:    return lo[0];
      WORD:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and registered read data.
module mem_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DW/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory responder: valid/ready request, WAIT_CYCLES wait states, held response.
// Optional MISALIGN_CHECK_EN rejects misaligned half/word accesses with resp_err_o.
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int CNT_W = $clog2(WAIT_CYCLES_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_CYCLES - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic accept, enter_resp;

  size_t                 in_size, q_size, a_size;
  logic [ADDR_WIDTH-1:0] in_addr, q_addr, a_addr;
  logic                  in_err, q_err, a_err;
  logic                  q_we, q_uns, a_we;
  logic [DATA_WIDTH-1:0] q_wdata, a_wdata;

  logic                  ram_en;
  logic [3:0]            ram_be;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, lane, load_data;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[31:ADDR_WIDTH];

  assign in_size = decode_size(req_size_i);

  // Low address bits below the access size are dropped so lanes are always aligned.
  always_comb begin
    in_addr = req_addr_i[ADDR_WIDTH-1:0];
    case (in_size)
      HALF:    in_addr[0]   = 1'b0;
      WORD:    in_addr[1:0] = 2'b00;
      default: ;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  assign in_err = misaligned(in_size, req_addr_i[1:0]);
`else
  assign in_err = 1'b0;
`endif

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == LAST_WAIT) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      q_addr   <= '0;
      q_size   <= BYTE;
      q_we     <= 1'b0;
      q_uns    <= 1'b0;
      q_err    <= 1'b0;
      q_wdata  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT && state_nxt == WAIT) ? wait_cnt + 1'b1 : '0;
      if (accept) begin
        q_addr  <= in_addr;
        q_size  <= in_size;
        q_we    <= req_we_i;
        q_uns   <= req_unsigned_i;
        q_err   <= in_err;
        q_wdata <= req_wdata_i;
      end
    end
  end

  // With zero wait states the RAM is accessed on the accept edge, before the fields are registered.
  always_comb begin
    if (state == IDLE) begin
      a_addr  = in_addr;
      a_size  = in_size;
      a_we    = req_we_i;
      a_err   = in_err;
      a_wdata = req_wdata_i;
    end else begin
      a_addr  = q_addr;
      a_size  = q_size;
      a_we    = q_we;
      a_err   = q_err;
      a_wdata = q_wdata;
    end
  end

  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = a_wdata;
    case (a_size)
      BYTE: begin
        ram_be    = 4'b0001 << a_addr[1:0];
        ram_wdata = {4{a_wdata[7:0]}};
      end
      HALF: begin
        ram_be    = a_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{a_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_en = enter_resp & ~a_err;

  mem_array #(
    .AW(ADDR_WIDTH - 2),
    .DW(DATA_WIDTH)
  ) u_mem (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (a_we),
    .be    (ram_be),
    .addr  (a_addr[ADDR_WIDTH-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign lane = ram_rdata >> {q_addr[1:0], 3'b000};

  always_comb begin
    load_data = ram_rdata;
    case (q_size)
      BYTE:    load_data = {{(DATA_WIDTH-8){~q_uns & lane[7]}}, lane[7:0]};
      HALF:    load_data = {{(DATA_WIDTH-16){~q_uns & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  assign resp_valid_o = (state == RESP);
  assign resp_rdata_o = (resp_valid_o && !q_we && !q_err) ? load_data : '0;

`ifdef MISALIGN_CHECK_EN
  assign resp_err_o = resp_valid_o & q_err;
`else
  assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench: a WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance for back-to-back.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_uns, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;

  logic        req_valid0, req_ready0, req_we0, req_uns0, resp_valid0, resp_ready0, resp_err0;
  logic [31:0] req_addr0, req_wdata0, resp_rdata0;
  logic [1:0]  req_size0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp10;

  data_mem_resp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  data_mem_resp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_addr_i(req_addr0),
    .req_we_i(req_we0), .req_size_i(req_size0), .req_unsigned_i(req_uns0), .req_wdata_i(req_wdata0),
    .resp_valid_o(resp_valid0), .resp_ready_i(resp_ready0), .resp_rdata_o(resp_rdata0), .resp_err_o(resp_err0)
  );

  // Issues one request to dut from IDLE, scrambles the inputs after acceptance,
  // and returns the response plus latency counted in edges from the accept edge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    req_addr = addr; req_we = we; req_size = size; req_uns = uns; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = ~addr; req_we = ~we; req_size = ~size; req_uns = ~uns; req_wdata = ~wdata;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
    checks++; if (resp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid0: got %b want 0", resp_valid0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_store_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word_store_rdata: got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_store_err: got %b want 0", er); end
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_load_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_rdata: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_load_err: got %b want 0", er); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b00, 1'b0, 32'h013, 32'h77777780, rd, er, lat);
    do_req(1'b0, 2'b00, 1'b0, 32'h013, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_signed: got %h want ffffff80", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL byte_load_unsigned: got %h want 00000080", rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL byte_store_word_view: got %h want 80adbeef", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h010, 32'h1234CAFE, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADCAFE) begin errors++; $display("FAIL half_store_word_view: got %h want 80adcafe", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h012, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF80AD) begin errors++; $display("FAIL half_load_signed: got %h want ffff80ad", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000CAFE) begin errors++; $display("FAIL half_load_unsigned: got %h want 0000cafe", rd); end
    do_req(1'b0, 2'b11, 1'b0, 32'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADCAFE) begin errors++; $display("FAIL size11_load: got %h want 80adcafe", rd); end
    exp10 = 32'h80ADCAFE;
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 2'b10, 1'b0, 32'h012, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL misalign_latency: got %0d want 3", lat); end
`ifdef MISALIGN_CHECK_EN
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_load: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'h011, 32'h11223344, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_store_err: got %b want 1", er); end
`else
    checks++; if (er !== 1'b0 || rd !== exp10) begin errors++; $display("FAIL misalign_load: got err=%b rdata=%h want err=0 rdata=%h", er, rd, exp10); end
    do_req(1'b1, 2'b10, 1'b0, 32'h011, 32'h11223344, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL misalign_store_err: got %b want 0", er); end
    exp10 = 32'h11223344;
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== exp10) begin errors++; $display("FAIL misalign_store_effect: got %h want %h", rd, exp10); end
    do_req(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, rd, er, lat);
    checks++; if (rd !== exp10) begin errors++; $display("FAIL alias_1010: got %h want %h", rd, exp10); end
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready = 1'b0;
    req_addr = 32'h010; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h030; req_we = 1'b1; req_wdata = 32'h99999999;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp10 || req_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold_%0d: got valid=%b rdata=%h ready=%b want 1 %h 0", i, resp_valid, resp_rdata, req_ready, exp10); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h020, 32'h12345678, rd, er, lat);
    req_addr = 32'h020; req_we = 1'b1; req_size = 2'b10; req_uns = 1'b0; req_wdata = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstwait_in_wait: got ready=%b want 0", req_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL rstwait_immediate: got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rstwait_discard: got %h want 12345678", rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== exp10) begin errors++; $display("FAIL reset_keeps_mem: got %h want %h", rd, exp10); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr_t [3] = '{32'h1010, 32'h010, 32'h1013};
    logic        we_t   [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  size_t_[3] = '{2'b10, 2'b10, 2'b00};
    logic        uns_t  [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] exp_t  [3] = '{32'h0, 32'hCAFEF00D, 32'h000000CA};
    int          rtime  [3] = '{-1, -1, -1};
    logic [31:0] rdat   [3] = '{32'h0, 32'h0, 32'h0};
    int k = 0;
    int nresp = 0;
    logic rdy;
    req_addr0 = addr_t[0]; req_we0 = we_t[0]; req_size0 = size_t_[0]; req_uns0 = uns_t[0];
    req_wdata0 = 32'hCAFEF00D;
    req_valid0 = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      rdy = req_ready0;
      @(posedge clk); #1;
      if (rdy && req_valid0) begin
        k++;
        if (k < 3) begin
          req_addr0 = addr_t[k]; req_we0 = we_t[k]; req_size0 = size_t_[k]; req_uns0 = uns_t[k];
          req_wdata0 = 32'h0;
        end else begin
          req_valid0 = 1'b0;
        end
      end
      if (resp_valid0 && nresp < 3) begin
        rtime[nresp] = cyc;
        rdat[nresp]  = resp_rdata0;
        nresp++;
      end
    end
    checks++; if (nresp !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", nresp); end
    checks++; if (rtime[0] !== 0) begin errors++; $display("FAIL b2b_first_latency: got %0d want 0", rtime[0]); end
    for (int i = 1; i < 3; i++) begin
      checks++; if (rtime[i] - rtime[i-1] !== 2) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d want 2", i, rtime[i] - rtime[i-1]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdat[i] !== exp_t[i]) begin errors++; $display("FAIL b2b_rdata_%0d: got %h want %h", i, rdat[i], exp_t[i]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = 2'b00; req_uns = 1'b0; req_wdata = '0;
    resp_ready = 1'b1;
    req_valid0 = 1'b0; req_addr0 = '0; req_we0 = 1'b0; req_size0 = 2'b00; req_uns0 = 1'b0; req_wdata0 = '0;
    resp_ready0 = 1'b1;
    exp10 = 32'h0;
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_backpressure();
    test_reset_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: byte-address bits decoded; storage is 2**ADDR_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default 32: word width; only 32 is supported.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states between acceptance and response, legal range 0..15.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  1  initiator presents a request.
REQ-007 req_ready_o  out  1  responder can accept a request.
REQ-008 req_addr_i  in  32  byte address.
REQ-009 req_we_i  in  1  1 = store, 0 = load.
REQ-010 req_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-011 req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_wdata_i  in  32  store data, right-aligned.
REQ-013 resp_valid_o  out  1  response available.
REQ-014 resp_ready_i  in  1  initiator consumes response.
REQ-015 resp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-016 resp_err_o  out  1  request was rejected (see Configuration).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-018 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i & req_ready_o at a rising edge.
REQ-019 On acceptance, all request fields SHALL be registered; later input changes SHALL be ignored until the next acceptance.
REQ-020 Transitions: IDLE->WAIT on acceptance when WAIT_CYCLES>0, else IDLE->RESP; WAIT->RESP after WAIT_CYCLES cycles in WAIT; RESP->IDLE when resp_ready_i=1.
REQ-021 Accept-to-resp_valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-022 The store SHALL be committed, and load data captured, at the edge entering RESP.
REQ-023 resp_valid_o SHALL be 1 exactly in RESP.
REQ-024 resp_valid_o, resp_rdata_o and resp_err_o SHALL hold stable until resp_ready_i is sampled high.
REQ-025 A new request SHALL NOT be accepted on the handshake edge; the earliest next acceptance is the following cycle.
REQ-026 Address bits above ADDR_WIDTH-1 SHALL be ignored, so accesses wrap modulo memory size.
REQ-027 Byte and half stores SHALL write only the lanes selected by addr[1:0]; the other bytes are unchanged.
REQ-028 Byte and half loads SHALL select the lane by addr[1:0] and extend per req_unsigned_i.
REQ-029 Memory contents SHALL be undefined at power-up.

Reset
REQ-030 While rst_i=0: state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, wait counter 0.
REQ-031 Reset asserted in WAIT SHALL discard the pending store, leaving memory unchanged.
REQ-032 Reset SHALL NOT clear memory contents.

Configuration
REQ-033 Macro MISALIGN_CHECK_EN SHALL control alignment checking.
REQ-034 With MISALIGN_CHECK_EN defined, a misaligned request (half with addr[0]=1, word with addr[1:0]!=0) SHALL produce:
- no memory write;
- resp_err_o=1 and resp_rdata_o=0;
- the same latency as a normal access.
REQ-035 Without MISALIGN_CHECK_EN, addr[0] SHALL be ignored for halves and addr[1:0] for words, and resp_err_o SHALL be tied to 0.

Structure
REQ-036 Shared package mem_pkg SHALL hold:
- the access-size enum (BYTE, HALF, WORD);
- the FSM state enum;
- the WAIT_CYCLES maximum constant.
REQ-037 Storage SHALL be a sub-module mem_array: single-port synchronous word RAM with 4-bit byte-enable write and registered read.

Verification
REQ-038 Word store 0xDEADBEEF to 0x010, then word load of 0x010 (WAIT_CYCLES=2) -> resp_valid_o rises 3 cycles after each acceptance; load returns 0xDEADBEEF with err 0.
REQ-039 Byte store 0x80 to 0x013, then loads of 0x013 -> signed load returns 0xFFFFFF80, unsigned load returns 0x00000080, word load of 0x010 returns 0x80ADBEEF.
REQ-040 Backpressure: hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o and data stay stable and req_ready_o=0; on release, IDLE is entered the next cycle.
REQ-041 Word load at 0x012:
- with MISALIGN_CHECK_EN: resp_err_o=1, rdata 0;
- without it: data from 0x010 is returned with err 0.
REQ-042 Assert rst_i=0 during WAIT of a store to 0x020 -> resp_valid_o=0 immediately; a later load of 0x020 returns the prior contents.
REQ-043 WAIT_CYCLES=0 with back-to-back requests and resp_ready_i=1 -> one response every 2 cycles; address 0x1010 aliases 0x010 when ADDR_WIDTH=12.
